path_walk: RTL
==============

# path_walk

Path readout engine for the node-array shortest-path solver. Once the array has converged, it reads per-node `path_dir`/`path_cost` back through a node-select port, starting at a goal node. It follows each predecessor direction back to the source node (cost 0) and streams the visited coordinates out over a valid/ready interface, goal first, source last. It sits between the node array's readback mux and the host/route consumer.

## Interface
Parameters:
- `W`, 32, grid width in nodes
- `H`, 32, grid height in nodes
- `XW`, 5, x coordinate width (≥ clog2(W))
- `YW`, 5, y coordinate width (≥ clog2(H))

Ports:
- `clk` in 1: sole clock; everything is on the rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin a walk; sampled only in IDLE
- `goal_x` in XW, `goal_y` in YW: starting node; latched on accepted `start`
- `rd_x` out XW, `rd_y` out YW: node select to the array readback mux
- `rd_cost` in 12: selected node cost; valid 1 cycle after `rd_x`/`rd_y`
- `rd_dir` in 3: selected node direction; same timing as `rd_cost`
- `out_valid` out 1, `out_ready` in 1: coordinate stream handshake
- `out_x` out XW, `out_y` out YW: coordinate of the current beat
- `out_last` out 1: current beat is the source node
- `busy` out 1: walk in progress
- `done` out 1: one-cycle pulse; last beat accepted
- `err` out 1: one-cycle pulse; walk aborted
- `steps` out 12: beats accepted in the current/last walk

## Operation
- Direction codes (predecessor offset): 0 N(y-1), 1 NE(x+1,y-1), 2 E(x+1), 3 SE(x+1,y+1), 4 S(y+1), 5 SW(x-1,y+1), 6 W(x-1), 7 NW(x-1,y-1).
- States: IDLE, FETCH, EVAL, EMIT, STEP.
- IDLE: on `start`, latch the goal into cur_x/cur_y, clear `steps`, go to FETCH. `start` is ignored outside IDLE.
- FETCH: drive `rd_x`/`rd_y` = cur. Go to EVAL.
- EVAL: register `rd_cost`/`rd_dir`.
  - cost == 12'hFFF (unreachable or inaccessible): pulse `err`, go to IDLE; no beat is emitted.
  - Otherwise go to EMIT with out_x/out_y = cur and `out_last` = (cost == 0).
- EMIT: hold `out_valid` and all beat fields stable until `out_ready`. On handshake, `steps` += 1.
  - If last: pulse `done`, go to IDLE.
  - Else go to STEP.
- STEP: compute next = cur + offset(dir) in signed arithmetic one bit wider than XW/YW.
  - next outside [0,W-1]×[0,H-1]: pulse `err`, go to IDLE.
  - `steps` == W·H: pulse `err`, go to IDLE (loop guard).
  - Otherwise cur ← next, go to FETCH.
- `rd_x`/`rd_y` hold the last driven value when not in FETCH.
- `busy` = (state != IDLE).
- On the error path `out_last` is never asserted. Beats already emitted stand.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_x`=`out_y`=0, `rd_x`=`rd_y`=0, `busy`=0, `done`=0, `err`=0, `steps`=0; state IDLE.
- `start` sampled at edge T → FETCH during T+1, EVAL during T+2, `out_valid` high from T+3.
- With `out_ready` held high, each node costs 4 cycles (FETCH, EVAL, EMIT, STEP).
- `done`/`err` are high for exactly the one cycle following the terminating edge, and `busy` is low in that same cycle. A new `start` may be sampled in that cycle.
- `rst` asserted in any state: return to IDLE at that edge, drop `out_valid` immediately, and emit no partial `done`/`err`.
- `out_ready` high while `out_valid` is low has no effect.

## Configuration
- `PATH_WALK_MONO_CHK_EN`
- Defined: EVAL also requires each fetched node's cost to be strictly less than the previous node's cost; the first node is exempt. A violation pulses `err` without emitting a beat. This catches an array read before convergence.
- Undefined: no cost-ordering check; logic and previous-cost register are compiled out.

## Test plan
- Goal = source (3,3), cost 0 → single beat (3,3) with `out_last`; `done` pulse; `steps`=1.
- Goal (5,2), array path E-chain: (5,2) dir 6 cost 4, (4,2) dir 6 cost 2, (3,2) cost 0 → beats (5,2),(4,2),(3,2), `last` on the third; `done`; `steps`=3.
- Diagonal: (2,2) dir 7 cost 6, (1,1) dir 7 cost 3, (0,0) cost 0 → beats (2,2),(1,1),(0,0). Toggle `out_ready` low for 5 cycles per beat → fields stable while stalled, no dropped or duplicated beats.
- Goal cost 12'hFFF → no `out_valid`, `err` pulses at T+3, `busy` low afterward.
- Node (0,4) dir 6 cost 8 → beat (0,4) emitted, then `err` (off-grid), `out_last` never high. Separately, a two-node dir loop with nonzero costs → `err` after W·H beats. With `PATH_WALK_MONO_CHK_EN` defined, the loop gives `err` at the second node instead.
- `rst` pulsed while EMIT is stalled on the second beat → `out_valid`/`busy` low next cycle, no `done`/`err`. A following `start` walks cleanly from the new goal.

Source files
------------

// File: rtl/path_walk_if.sv
// Node readback select/return plus the coordinate stream toward the route consumer.
// No storage: wires only, the engine side owns timing.
// out_valid/out_ready is a plain valid-ready pair; readback is fixed one-cycle latency.
interface path_walk_if #(
   parameter int XW = 5,
   parameter int YW = 5
);
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic [11:0]   rd_cost;
   logic [2:0]    rd_dir;
   logic          out_valid;
   logic          out_ready;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_last;

   modport master (
      output rd_x, rd_y,
      input  rd_cost, rd_dir,
      output out_valid, out_x, out_y, out_last,
      input  out_ready
   );

   modport slave (
      input  rd_x, rd_y,
      output rd_cost, rd_dir,
      input  out_valid, out_x, out_y, out_last,
      output out_ready
   );
endinterface

// File: rtl/path_walk.sv
// Walks predecessor directions from a goal node back to the source, streaming coordinates.
// First beat valid 3 cycles after start; 4 cycles per node with out_ready held high.
// EMIT holds the beat until out_ready; optional PATH_WALK_MONO_CHK_EN adds cost-ordering check.
module path_walk #(
   parameter int W  = 32,
   parameter int H  = 32,
   parameter int XW = 5,
   parameter int YW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [XW-1:0] goal_x,
   input  logic [YW-1:0] goal_y,
   path_walk_if.master   bus,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [11:0]   steps
);
   localparam logic [11:0] COST_INF   = 12'hFFF;
   localparam logic [11:0] STEP_LIMIT = 12'(W * H);

   typedef enum logic [2:0] {IDLE, FETCH, EVAL, EMIT, STEP} state_t;

   state_t            state, state_n;
   logic [XW-1:0]     cur_x, rd_hold_x, out_x_q;
   logic [YW-1:0]     cur_y, rd_hold_y, out_y_q;
   logic [2:0]        dir_q;
   logic              last_q;
   logic [11:0]       steps_q;
   logic              done_q, err_q;
   logic signed [XW:0] dx, nx;
   logic signed [YW:0] dy, ny;
   logic              off_grid;
   logic              mono_bad;
   logic              load_goal, take_node, beat_hs, walk_done, walk_err, advance;

`ifdef PATH_WALK_MONO_CHK_EN
   logic [11:0] prev_cost;
   logic        first_node;

   // Track the previously accepted cost; the goal node has nothing to compare against.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_cost  <= '0;
         first_node <= 1'b1;
      end else if (load_goal) begin
         first_node <= 1'b1;
      end else if (take_node) begin
         prev_cost  <= bus.rd_cost;
         first_node <= 1'b0;
      end
   end

   assign mono_bad = !first_node && (bus.rd_cost >= prev_cost);
`else
   assign mono_bad = 1'b0;
`endif

   // Decode the predecessor direction into signed x/y offsets.
   always_comb begin
      dx = '0;
      dy = '0;
      case (dir_q)
         3'd1, 3'd2, 3'd3: dx = {{XW{1'b0}}, 1'b1};
         3'd5, 3'd6, 3'd7: dx = '1;
         default:          dx = '0;
      endcase
      case (dir_q)
         3'd0, 3'd1, 3'd7: dy = '1;
         3'd3, 3'd4, 3'd5: dy = {{YW{1'b0}}, 1'b1};
         default:          dy = '0;
      endcase
   end

   assign nx = $signed({1'b0, cur_x}) + dx;
   assign ny = $signed({1'b0, cur_y}) + dy;
   // Widen to int so the upper bound test stays meaningful when W or H fill the coordinate width.
   assign off_grid = (int'(nx) < 0) || (int'(nx) >= W) || (int'(ny) < 0) || (int'(ny) >= H);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_n   = state;
      load_goal = 1'b0;
      take_node = 1'b0;
      beat_hs   = 1'b0;
      walk_done = 1'b0;
      walk_err  = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_goal = 1'b1;
               state_n   = FETCH;
            end
         end
         FETCH: state_n = EVAL;
         EVAL: begin
            if (bus.rd_cost == COST_INF || mono_bad) begin
               walk_err = 1'b1;
               state_n  = IDLE;
            end else begin
               take_node = 1'b1;
               state_n   = EMIT;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               beat_hs = 1'b1;
               if (last_q) begin
                  walk_done = 1'b1;
                  state_n   = IDLE;
               end else begin
                  state_n = STEP;
               end
            end
         end
         STEP: begin
            if (off_grid || steps_q == STEP_LIMIT) begin
               walk_err = 1'b1;
               state_n  = IDLE;
            end else begin
               advance = 1'b1;
               state_n = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Walk datapath: current node, held readback select, beat fields, counters and pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_x     <= '0;
         cur_y     <= '0;
         rd_hold_x <= '0;
         rd_hold_y <= '0;
         out_x_q   <= '0;
         out_y_q   <= '0;
         dir_q     <= '0;
         last_q    <= 1'b0;
         steps_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= walk_done;
         err_q  <= walk_err;
         if (load_goal) begin
            cur_x   <= goal_x;
            cur_y   <= goal_y;
            steps_q <= '0;
         end
         if (advance) begin
            cur_x <= nx[XW-1:0];
            cur_y <= ny[YW-1:0];
         end
         if (state == FETCH) begin
            rd_hold_x <= cur_x;
            rd_hold_y <= cur_y;
         end
         if (take_node) begin
            out_x_q <= cur_x;
            out_y_q <= cur_y;
            last_q  <= (bus.rd_cost == 12'd0);
            dir_q   <= bus.rd_dir;
         end
         if (beat_hs) steps_q <= steps_q + 12'd1;
      end
   end

   assign bus.rd_x      = (state == FETCH) ? cur_x : rd_hold_x;
   assign bus.rd_y      = (state == FETCH) ? cur_y : rd_hold_y;
   assign bus.out_valid = (state == EMIT);
   assign bus.out_x     = out_x_q;
   assign bus.out_y     = out_y_q;
   assign bus.out_last  = (state == EMIT) && last_q;
   assign busy          = (state != IDLE);
   assign done          = done_q;
   assign err           = err_q;
   assign steps         = steps_q;
endmodule
